// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants, types and byte-classification helpers for the PS/2
// scancode decoder. Imported by ps2_rx_frame and ps2_scancode_decoder.
// No ports (package).
package ps2_pkg;

    // Prefix bytes that modify or suppress the following code byte
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_REL   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Keyboard responses and BAT results; never reported as key events
    // unless a prefix is pending
    localparam int         PS2_NUM_RESPONSES = 7;
    localparam logic [7:0] PS2_RESPONSE_CODES [PS2_NUM_RESPONSES] =
        '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    // Fake shifts the keyboard wraps around extended keys
    localparam logic [7:0] PS2_FAKE_SHIFT_L = 8'h12;
    localparam logic [7:0] PS2_FAKE_SHIFT_R = 8'h59;

    // start + 8 data + parity + stop
    localparam int         PS2_FRAME_BITS = 11;

    // Bytes left in the 8-byte Pause sequence after its leading E1
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Frame receiver state
    typedef enum logic {
        RX_IDLE,
        RX_RECEIVE
    } rx_state_e;

    // What a received byte means to the prefix tracker
    typedef enum logic [2:0] {
        BYTE_SKIP,
        BYTE_PAUSE,
        BYTE_EXT,
        BYTE_REL,
        BYTE_RESPONSE,
        BYTE_FAKE_SHIFT,
        BYTE_KEY
    } byte_class_e;

    function automatic logic is_response(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_RESPONSES; i++) begin
            if (b == PS2_RESPONSE_CODES[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == PS2_FAKE_SHIFT_L) || (b == PS2_FAKE_SHIFT_R);
    endfunction

    // Priority order matters: an active Pause skip swallows everything,
    // and prefixes are recognised before the response/fake-shift filters.
    function automatic byte_class_e classify_byte(
        input logic [7:0] b,
        input logic       ext_flag,
        input logic       rel_flag,
        input logic       skipping
    );
        byte_class_e cls;
        if (skipping) begin
            cls = BYTE_SKIP;
        end else if (b == PS2_PAUSE) begin
            cls = BYTE_PAUSE;
        end else if (b == PS2_EXT) begin
            cls = BYTE_EXT;
        end else if (b == PS2_REL) begin
            cls = BYTE_REL;
        end else if (!ext_flag && !rel_flag && is_response(b)) begin
            cls = BYTE_RESPONSE;
        end else if (ext_flag && is_fake_shift(b)) begin
            cls = BYTE_FAKE_SHIFT;
        end else begin
            cls = BYTE_KEY;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Synchronises and filters the raw PS/2 lines, deserialises 11-bit frames,
// checks odd parity and the stop bit, and aborts stalled frames.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw PS/2 clock (asynchronous)
//   ps2_data        raw PS/2 data (asynchronous)
//   rx_byte[7:0]    last deserialised byte (valid when byte_valid pulses)
//   byte_valid      1-cycle strobe, one cycle after the stop-bit edge
//   frame_error     1-cycle strobe on parity, stop-bit or timeout failure
//   timeout         1-cycle strobe when the watchdog aborts a frame
//   rx_busy         high while a frame is in progress
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 56000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error,
    output logic       timeout,
    output logic       rx_busy
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic              ps2_clk_meta_q, ps2_clk_sync_q;
    logic              ps2_data_meta_q, ps2_data_sync_q;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              filt_clk_q, filt_clk_d;
    logic              filt_clk_dly_q;
    logic              fall_edge;

    rx_state_e         state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_error_q, frame_error_d;
    logic              timeout_q, timeout_d;

    logic              last_bit;
    logic              wd_expired;

    // Idle PS/2 lines sit high, so the synchroniser and filter reset high
    // to avoid a spurious falling edge straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
            filt_cnt_q      <= '0;
            filt_clk_q      <= 1'b1;
            filt_clk_dly_q  <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
            filt_cnt_q      <= filt_cnt_d;
            filt_clk_q      <= filt_clk_d;
            filt_clk_dly_q  <= filt_clk_q;
        end
    end

    // Any sample matching the current filtered level restarts the count,
    // so only FILTER_LEN consecutive differing samples flip the level.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (ps2_clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_clk_d = ps2_clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    assign fall_edge  = filt_clk_dly_q & ~filt_clk_q;
    assign last_bit   = (bit_cnt_q == 4'(PS2_FRAME_BITS - 1));
    assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RX_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            wd_cnt_q      <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            wd_cnt_q      <= wd_cnt_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next state: a falling edge with data low is a start bit; a frame
    // ends at the stop-bit edge or when the watchdog expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: begin
                if (fall_edge && !ps2_data_sync_q) begin
                    state_d = RX_RECEIVE;
                end
            end
            RX_RECEIVE: begin
                if (fall_edge) begin
                    if (last_bit) begin
                        state_d = RX_IDLE;
                    end
                end else if (wd_expired) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Datapath: bit_cnt 1..8 shift data in LSB first, 9 is parity, 10 is
    // stop. Result strobes are registered, giving one cycle of latency.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        wd_cnt_d      = wd_cnt_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            RX_IDLE: begin
                wd_cnt_d  = '0;
                bit_cnt_d = '0;
                if (fall_edge && !ps2_data_sync_q) begin
                    bit_cnt_d = 4'd1;
                end
            end
            RX_RECEIVE: begin
                if (fall_edge) begin
                    wd_cnt_d  = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q <= 4'd8) begin
                        shift_d = {ps2_data_sync_q, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd9) begin
                        parity_d = ps2_data_sync_q;
                    end else begin
                        bit_cnt_d = '0;
                        // Odd parity: data ones plus parity bit must be odd
                        if (ps2_data_sync_q && (^shift_q ^ parity_q)) begin
                            byte_valid_d = 1'b1;
                        end else begin
                            frame_error_d = 1'b1;
                        end
                    end
                end else if (wd_expired) begin
                    wd_cnt_d      = '0;
                    bit_cnt_d     = '0;
                    frame_error_d = 1'b1;
                    timeout_d     = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            default: begin
                bit_cnt_d = '0;
                wd_cnt_d  = '0;
            end
        endcase
    end

    assign rx_byte     = shift_q;
    assign byte_valid  = byte_valid_q;
    assign frame_error = frame_error_q;
    assign timeout     = timeout_q;
    assign rx_busy     = (state_q == RX_RECEIVE);

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the raw PS/2 keyboard line into key events: an 8-bit scancode with
// extended (E0) and released (F0) flags. Strips prefixes, the Pause
// sequence, fake shifts and keyboard response bytes.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw PS/2 clock (asynchronous)
//   ps2_data        raw PS/2 data (asynchronous)
//   scan_received   1-cycle strobe: new event valid
//   scancode[7:0]   event code byte, held until the next event
//   extended        event had an E0 prefix, held
//   released        event had an F0 prefix, held
//   frame_error     1-cycle strobe on parity, stop-bit or timeout failure
//   rx_busy         high while a frame is in progress
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 56000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_received,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       frame_error,
    output logic       rx_busy
);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        rx_frame_error;
    logic        rx_timeout;

    logic        ext_q, ext_d;
    logic        rel_q, rel_d;
    logic [2:0]  skip_q, skip_d;
    logic        scan_received_q, scan_received_d;
    logic [7:0]  scancode_q, scancode_d;
    logic        extended_q, extended_d;
    logic        released_q, released_d;

    byte_class_e byte_class;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .frame_error (rx_frame_error),
        .timeout     (rx_timeout),
        .rx_busy     (rx_busy)
    );

    assign byte_class = classify_byte(rx_byte, ext_q, rel_q, skip_q != 3'd0);

    // Prefix state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q           <= 1'b0;
            rel_q           <= 1'b0;
            skip_q          <= '0;
            scan_received_q <= 1'b0;
            scancode_q      <= '0;
            extended_q      <= 1'b0;
            released_q      <= 1'b0;
        end else begin
            ext_q           <= ext_d;
            rel_q           <= rel_d;
            skip_q          <= skip_d;
            scan_received_q <= scan_received_d;
            scancode_q      <= scancode_d;
            extended_q      <= extended_d;
            released_q      <= released_d;
        end
    end

    // Prefix tracking. A timed-out frame may have been the code a prefix
    // was waiting for, so the prefixes are dropped with it; a parity or
    // stop-bit error leaves them alone.
    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (rx_timeout) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (byte_valid) begin
            case (byte_class)
                BYTE_SKIP:  skip_d = skip_q - 3'd1;
                BYTE_PAUSE: skip_d = PS2_PAUSE_SKIP;
                BYTE_EXT:   ext_d  = 1'b1;
                BYTE_REL:   rel_d  = 1'b1;
                BYTE_FAKE_SHIFT, BYTE_KEY: begin
                    ext_d = 1'b0;
                    rel_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Event outputs only move when a real key code completes
    always_comb begin
        scan_received_d = byte_valid && !rx_timeout && (byte_class == BYTE_KEY);
        scancode_d      = scancode_q;
        extended_d      = extended_q;
        released_d      = released_q;
        if (scan_received_d) begin
            scancode_d = rx_byte;
            extended_d = ext_q;
            released_d = rel_q;
        end
    end

    assign scan_received = scan_received_q;
    assign scancode      = scancode_q;
    assign extended      = extended_q;
    assign released      = released_q;
    assign frame_error   = rx_frame_error;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
// Drives PS/2 frames into ps2_scancode_decoder and compares the reported
// events and frame errors against a byte-level model of the prefix rules.
module tb_ps2_scancode_decoder;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    // raw fall -> 2 synchroniser stages -> FILTER_LEN filter samples
    // -> edge detected -> byte_valid -> scan_received
    localparam int LATENCY        = 2 + FILTER_LEN + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       scan_received;
    logic [7:0] scancode;
    logic       extended;
    logic       released;
    logic       frame_error;
    logic       rx_busy;

    ps2_scancode_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .scan_received (scan_received),
        .scancode      (scancode),
        .extended      (extended),
        .released      (released),
        .frame_error   (frame_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] ev_q[$];
    logic [9:0] exp_q[$];
    int ev_cyc = -1;
    int stop_fall_cyc = 0;
    int err_cnt = 0;
    int exp_err = 0;
    int pass_count = 0;
    int check_count = 0;
    int fail_count = 0;

    // Reference model state: pending prefixes and bytes left to swallow
    bit m_ext = 1'b0;
    bit m_rel = 1'b0;
    int m_skip = 0;

    // Record every event and every frame error the DUT reports
    always @(negedge clk) begin
        if (!rst) begin
            if (scan_received) begin
                ev_q.push_back({extended, released, scancode});
                ev_cyc = cyc;
            end
            if (frame_error) err_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (m_skip != 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (!m_ext && !m_rel &&
                     (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
            // keyboard response, dropped
        end else if (m_ext && (b inside {8'h12, 8'h59})) begin
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else begin
            exp_q.push_back({m_ext, m_rel, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic modelClear();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    // Bit-bangs the first nbits bits of a frame; optional glitches of
    // FILTER_LEN-1 cycles sit in the middle of every clock phase.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                 input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (10) @(negedge clk);
            if (i == 10) stop_fall_cyc = cyc;
            ps2_clk = 1'b0;
            if (glitch) begin
                repeat (12) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (FILTER_LEN - 1) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (11) @(negedge clk);
            end else begin
                repeat (30) @(negedge clk);
            end
            ps2_clk = 1'b1;
            if (glitch) begin
                repeat (12) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (FILTER_LEN - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (11) @(negedge clk);
            end else begin
                repeat (30) @(negedge clk);
            end
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit glitch);
        applyStimulus(b, 1'b0, 1'b0, glitch, 11);
        modelByte(b);
    endtask

    task automatic checkEvents(input string tag);
        logic [9:0] o;
        logic [9:0] e;
        checkOutput({tag, " event count"}, ev_q.size(), exp_q.size());
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            o = ev_q.pop_front();
            e = exp_q.pop_front();
            checkOutput({tag, " scancode"}, 32'(o[7:0]), 32'(e[7:0]));
            checkOutput({tag, " extended"}, 32'(o[9]), 32'(e[9]));
            checkOutput({tag, " released"}, 32'(o[8]), 32'(e[8]));
        end
        ev_q.delete();
        exp_q.delete();
        checkOutput({tag, " frame errors"}, err_cnt, exp_err);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        bit bad;
        bit gl;

        $display("[TB] reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset scan_received", 32'(scan_received), 0);
        checkOutput("reset scancode", 32'(scancode), 0);
        checkOutput("reset extended", 32'(extended), 0);
        checkOutput("reset released", 32'(released), 0);
        checkOutput("reset frame_error", 32'(frame_error), 0);
        checkOutput("reset rx_busy", 32'(rx_busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] single make code and latency");
        sendByte(8'h1C, 1'b0);
        checkOutput("1C latency", ev_cyc - stop_fall_cyc, LATENCY);
        checkOutput("strobe low after event", 32'(scan_received), 0);
        checkOutput("scancode held", 32'(scancode), 32'h1C);
        checkEvents("1C");

        $display("[TB] prefixes");
        sendByte(8'hF0, 1'b0); sendByte(8'h1C, 1'b0);
        checkEvents("F0 1C");
        sendByte(8'hE0, 1'b0); sendByte(8'hF0, 1'b0); sendByte(8'h75, 1'b0);
        checkEvents("E0 F0 75");
        sendByte(8'hF0, 1'b0); sendByte(8'hE0, 1'b0); sendByte(8'h75, 1'b0);
        checkEvents("F0 E0 75");

        $display("[TB] pause sequence");
        sendByte(8'hE1, 1'b0); sendByte(8'h14, 1'b0); sendByte(8'h77, 1'b0);
        sendByte(8'hE1, 1'b0); sendByte(8'hF0, 1'b0); sendByte(8'h14, 1'b0);
        sendByte(8'hF0, 1'b0); sendByte(8'h77, 1'b0);
        checkEvents("pause");
        sendByte(8'h29, 1'b0);
        checkEvents("after pause");

        $display("[TB] parity and stop errors");
        applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0, 11);
        exp_err++;
        checkEvents("bad parity");
        sendByte(8'h1C, 1'b0);
        checkEvents("after bad parity");
        sendByte(8'hF0, 1'b0);
        applyStimulus(8'h2B, 1'b0, 1'b1, 1'b0, 11);
        exp_err++;
        sendByte(8'h2B, 1'b0);
        checkEvents("bad stop keeps prefix");

        $display("[TB] timeout");
        sendByte(8'hE0, 1'b0);
        applyStimulus(8'h75, 1'b0, 1'b0, 1'b0, 5);
        checkOutput("busy mid-frame", 32'(rx_busy), 1);
        repeat (TIMEOUT_CYCLES - 200) @(negedge clk);
        checkOutput("no early timeout", err_cnt, exp_err);
        checkOutput("busy before timeout", 32'(rx_busy), 1);
        repeat (300) @(negedge clk);
        exp_err++;
        modelClear();
        checkOutput("idle after timeout", 32'(rx_busy), 0);
        checkEvents("timeout");
        sendByte(8'h75, 1'b0);
        checkEvents("after timeout");

        $display("[TB] glitches and filtered bytes");
        sendByte(8'h1C, 1'b1);
        checkEvents("glitched 1C");
        sendByte(8'hAA, 1'b0);
        checkEvents("AA dropped");
        sendByte(8'hE0, 1'b0); sendByte(8'h12, 1'b0);
        checkEvents("fake shift");
        sendByte(8'h75, 1'b0);
        checkEvents("after fake shift");

        $display("[TB] reset mid-frame");
        sendByte(8'hE0, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b0, 5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset mid-frame busy", 32'(rx_busy), 0);
        checkOutput("reset mid-frame scancode", 32'(scancode), 0);
        rst = 1'b0;
        modelClear();
        repeat (5) @(negedge clk);
        sendByte(8'h33, 1'b0);
        checkEvents("after reset");

        $display("[TB] random bytes");
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'hF0;
                3: b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
                4: b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 7) == 0);
            gl  = ($urandom_range(0, 3) == 0);
            if (bad) begin
                applyStimulus(b, 1'b1, 1'b0, gl, 11);
                exp_err++;
            end else begin
                sendByte(b, gl);
            end
            checkEvents("random");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
